ctrl_pipe_regs: RTL
===================

Name: ctrl_pipe_regs

Overview:
Parametrised replacement for the fixed ID_EX / EX_MEM / MEM_WB control-signal registers. It carries a WIDTH-bit control word through STAGES back-to-back pipeline registers, each with its own valid bit. It adds hazard support: bubble insertion on a load-use stall, multi-stage squash on a taken branch, and a global freeze. It sits between the CU mux output (ID) and the EX/MEM/WB consumers; consumers slice the fields they need from each stage's word.

Parameters:
WIDTH, 16, control word width in bits (opcode, AM, S, load, RF, size, RW, enable, ...)
STAGES, 3, number of pipeline registers; stage 0 = ID/EX, stage STAGES-1 = last (WB); STAGES >= 2
FLUSH_DEPTH, 2, number of youngest stages loaded with bubbles on flush; 1 <= FLUSH_DEPTH <= STAGES
CNT_W, 16, width of the bubble counter

Ports:
clk  input  1  rising-edge clock
R  input  1  asynchronous reset, active-low
in_valid  input  1  in_ctrl holds a real instruction
in_ctrl  input  WIDTH  control word from ID (CU mux)
stall  input  1  load-use stall: insert a bubble at stage 0; older stages advance
flush  input  1  branch squash: FLUSH_DEPTH youngest stages become bubbles
hold  input  1  global freeze: no register changes
out_ctrl  output  STAGES*WIDTH  flat; bits [k*WIDTH +: WIDTH] = stage k word
out_valid  output  STAGES  bit k = stage k valid
occupancy  output  $clog2(STAGES+1)  number of set out_valid bits
bubble_count  output  CNT_W  saturating count of bubble-insertion cycles

Behaviour:
- Reset (R=0, takes effect immediately without a clock edge): all stage words = 0, out_valid = 0, occupancy = 0, bubble_count = 0. Release is synchronous to the next clk rising edge; first capture happens on the first edge with R=1.
- Bubble = word 0, valid 0. An invalid stage always holds word 0; in_ctrl is zeroed when in_valid=0.
- Priority per edge: hold > flush > stall > normal.
- normal: stage0 <= (in_valid ? in_ctrl : 0), valid0 <= in_valid; stage k <= stage k-1 for k >= 1 (word and valid). Latency is 1 cycle to stage 0 and k+1 cycles to stage k.
- stall (no flush, no hold): stage0 <= bubble; stage k <= stage k-1 for k >= 1. The stalled in_ctrl is dropped here; upstream (PC, IF_ID LE) re-presents it.
- flush (no hold): stages 0..FLUSH_DEPTH-1 <= bubble; stage k <= stage k-1 for k >= FLUSH_DEPTH. in_ctrl and old stages 0..FLUSH_DEPTH-2 are discarded. With FLUSH_DEPTH=1, flush behaves identically to stall.
- hold: all stage words, valids and bubble_count keep their values, regardless of stall, flush or in_valid.
- bubble_count: +1 on each edge with hold=0 and (stall|flush)=1. It saturates at 2^CNT_W-1 and does not wrap. The count is per edge, not per bubble stage.
- occupancy: combinational popcount of the registered out_valid, so it changes only after an edge or on reset.
- Outputs come straight from registers; there is no combinational path from inputs to outputs.
- The oldest stage's word is discarded when it shifts out; there is no backpressure from the last stage.

Test Plan:
1. Streaming (WIDTH=16, STAGES=3): in_valid=1, in_ctrl 0xA001, 0xA002, 0xA003 on consecutive edges -> after edge 3: stage0=0xA003, stage1=0xA002, stage2=0xA001, out_valid=3'b111, occupancy=3; edge 4 with in_valid=0 -> stage0=0, valid0=0, stage2=0xA002, occupancy=2.
2. Stall: pipe holds 0xA003/0xA002/0xA001, stall=1 for one edge with in_ctrl=0xB004 -> stage0=0 (valid 0), stage1=0xA003, stage2=0xA002, bubble_count=1.
3. Flush (FLUSH_DEPTH=2): pipe holds 0xA003/0xA002/0xA001, flush=1 and stall=1 together -> stage0=0, stage1=0, stage2=0xA002, out_valid=3'b100, bubble_count +1 (not +2).
4. Hold priority: hold=1 with flush=1, stall=1, in_ctrl=0xC005 for 3 edges -> all stages, out_valid and bubble_count unchanged.
5. Async reset mid-stream: full pipe, drive R=0 between clock edges -> out_ctrl=0, out_valid=0, occupancy=0, bubble_count=0 before the next edge. After release, the first edge with in_ctrl=0xD006 valid loads stage0=0xD006.
6. Saturation (CNT_W=4): stall=1 for 20 edges -> bubble_count reaches 15 and stays at 15.

Source files
------------

// File: rtl/ctrl_pipe_regs.sv
// rtl/ctrl_pipe_regs.sv - parametrised control-word pipeline registers with stall/flush/hold
module ctrl_pipe_regs #(
    parameter int WIDTH       = 16,
    parameter int STAGES      = 3,
    parameter int FLUSH_DEPTH = 2,
    parameter int CNT_W       = 16
) (
    input  logic                      clk,
    input  logic                      R,
    input  logic                      in_valid,
    input  logic [WIDTH-1:0]          in_ctrl,
    input  logic                      stall,
    input  logic                      flush,
    input  logic                      hold,
    output logic [STAGES*WIDTH-1:0]   out_ctrl,
    output logic [STAGES-1:0]         out_valid,
    output logic [$clog2(STAGES+1)-1:0] occupancy,
    output logic [CNT_W-1:0]          bubble_count
);

    localparam int OCC_W = $clog2(STAGES+1);

    logic [WIDTH-1:0] word_q [STAGES];
    logic [STAGES-1:0] valid_q;
    logic [CNT_W-1:0]  bubble_q;
    logic [OCC_W-1:0]  occ;

    always_ff @(posedge clk or negedge R) begin
        if (!R) begin
            for (int k = 0; k < STAGES; k++) begin
                word_q[k] <= '0;
            end
            valid_q  <= '0;
            bubble_q <= '0;
        end else if (!hold) begin
            for (int k = 0; k < STAGES; k++) begin
                // Flushed stages become bubbles; stage 0 otherwise takes ID, the rest shift.
                if (flush && (k < FLUSH_DEPTH)) begin
                    word_q[k]  <= '0;
                    valid_q[k] <= 1'b0;
                end else if (k == 0) begin
                    word_q[k]  <= (in_valid && !stall) ? in_ctrl : '0;
                    valid_q[k] <= in_valid && !stall;
                end else begin
                    word_q[k]  <= word_q[k-1];
                    valid_q[k] <= valid_q[k-1];
                end
            end
            if ((stall || flush) && (bubble_q != {CNT_W{1'b1}})) begin
                bubble_q <= bubble_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        occ = '0;
        for (int k = 0; k < STAGES; k++) begin
            occ = occ + OCC_W'(valid_q[k]);
        end
    end

    genvar g;
    generate
        for (g = 0; g < STAGES; g++) begin : g_out
            assign out_ctrl[g*WIDTH +: WIDTH] = word_q[g];
        end
    endgenerate

    assign out_valid    = valid_q;
    assign occupancy    = occ;
    assign bubble_count = bubble_q;

endmodule
